// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide for EX; define MULDIV_FAST_MUL_EN for a single-cycle multiplier.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam logic [4:0] OP_MUL    = 5'b01010;
    localparam logic [4:0] OP_MULH   = 5'b01011;
    localparam logic [4:0] OP_MULHSU = 5'b01100;
    localparam logic [4:0] OP_MULHU  = 5'b01101;
    localparam logic [4:0] OP_DIV    = 5'b01110;
    localparam logic [4:0] OP_DIVU   = 5'b01111;
    localparam logic [4:0] OP_REM    = 5'b10000;
    localparam logic [4:0] OP_REMU   = 5'b10001;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      r_state;
    logic [4:0]  r_op, r_cnt;
    logic        r_neg, r_done;
    logic [31:0] r_acc, r_q, r_b, r_result;

    // The sign fix-up: products negate as a 64-bit value, quotient/remainder per half.
    function automatic logic [31:0] f_result(input logic [4:0] op, input logic neg, input logic [63:0] v);
        logic [63:0] p;
        logic [31:0] q, r;
        p = neg ? -v : v;
        q = neg ? -v[31:0] : v[31:0];
        r = neg ? -v[63:32] : v[63:32];
        return (op == OP_MUL) ? p[31:0] :
               (op <= OP_MULHU) ? p[63:32] :
               (op == OP_DIV || op == OP_DIVU) ? q : r;
    endfunction

    logic        w_is_m, w_is_mul, w_is_div, w_sa, w_sb, w_a_neg, w_b_neg, w_neg;
    logic        w_quot, w_b_zero, w_ovf, w_spec, w_imm_go, w_mul_mode, w_ge;
    logic [31:0] w_a_mag, w_b_mag, w_spec_res, w_imm_res, w_diff, w_acc_n, w_q_n, w_calc_res;
    logic [32:0] w_sh, w_sum;

    assign w_is_m   = (op_i >= OP_MUL) && (op_i <= OP_REMU);
    assign w_is_mul = w_is_m && (op_i <= OP_MULHU);
    assign w_is_div = w_is_m && !w_is_mul;
    assign w_sa     = op_i == OP_MUL || op_i == OP_MULH || op_i == OP_MULHSU || op_i == OP_DIV || op_i == OP_REM;
    assign w_sb     = op_i == OP_MUL || op_i == OP_MULH || op_i == OP_DIV || op_i == OP_REM;
    assign w_a_neg  = w_sa & a_i[31];
    assign w_b_neg  = w_sb & b_i[31];
    assign w_a_mag  = w_a_neg ? -a_i : a_i;
    assign w_b_mag  = w_b_neg ? -b_i : b_i;
    assign w_neg    = (op_i == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_quot     = op_i == OP_DIV || op_i == OP_DIVU;
    assign w_b_zero   = b_i == 32'd0;
    assign w_ovf      = (op_i == OP_DIV || op_i == OP_REM) && a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF;
    assign w_spec     = w_is_div && (w_b_zero || w_ovf);
    assign w_spec_res = w_b_zero ? (w_quot ? 32'hFFFF_FFFF : a_i) : (w_quot ? a_i : 32'd0);

`ifdef MULDIV_FAST_MUL_EN
    assign w_imm_go  = w_spec || w_is_mul;
    assign w_imm_res = w_is_mul ? f_result(op_i, w_neg, {32'd0, w_a_mag} * {32'd0, w_b_mag}) : w_spec_res;
`else
    assign w_imm_go  = w_spec;
    assign w_imm_res = w_spec_res;
`endif

    // r_acc is the remainder (divide) or upper partial product (multiply); r_q the quotient or multiplier.
    assign w_mul_mode = r_op <= OP_MULHU;
    assign w_sh       = {r_acc, r_q[31]};
    assign w_ge       = w_sh >= {1'b0, r_b};
    assign w_diff     = w_sh[31:0] - r_b;
    assign w_sum      = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : 33'd0);
    assign w_acc_n    = w_mul_mode ? w_sum[32:1] : (w_ge ? w_diff : w_sh[31:0]);
    assign w_q_n      = w_mul_mode ? {w_sum[0], r_q[31:1]} : {r_q[30:0], w_ge};
    assign w_calc_res = f_result(r_op, r_neg, {w_acc_n, w_q_n});

    assign stall_o  = start_i & w_is_m & (r_state != DONE) & ~flush_i & ~reset;
    assign done_o   = r_done;
    assign result_o = r_result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= 5'd0;
            r_done   <= 1'b0;
            r_result <= 32'd0;
            r_op     <= 5'd0;
            r_neg    <= 1'b0;
            r_acc    <= 32'd0;
            r_q      <= 32'd0;
            r_b      <= 32'd0;
        end else if (flush_i) begin
            r_state <= IDLE;
            r_cnt   <= 5'd0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start_i && w_is_m) begin
                        r_op  <= op_i;
                        r_neg <= w_neg;
                        r_acc <= 32'd0;
                        r_q   <= w_a_mag;
                        r_b   <= w_b_mag;
                        r_cnt <= 5'd0;
                        if (w_imm_go) begin
                            r_result <= w_imm_res;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_acc <= w_acc_n;
                    r_q   <= w_q_n;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_result <= w_calc_res;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed checks of results, stall counts, flush and reset for ex_muldiv_unit.
module tb_ex_muldiv_unit;
    localparam logic [4:0] OP_MUL    = 5'b01010;
    localparam logic [4:0] OP_MULH   = 5'b01011;
    localparam logic [4:0] OP_MULHSU = 5'b01100;
    localparam logic [4:0] OP_MULHU  = 5'b01101;
    localparam logic [4:0] OP_DIV    = 5'b01110;
    localparam logic [4:0] OP_DIVU   = 5'b01111;
    localparam logic [4:0] OP_REM    = 5'b10000;
    localparam logic [4:0] OP_REMU   = 5'b10001;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_STALLS = 1;
`else
    localparam int MUL_STALLS = 33;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [4:0]  op_i = 5'd0;
    logic [31:0] a_i = 32'd0;
    logic [31:0] b_i = 32'd0;
    logic        flush_i = 1'b0;
    logic        stall_o, done_o;
    logic [31:0] result_o;
    int          checks = 0;
    int          errors = 0;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .flush_i(flush_i), .stall_o(stall_o), .done_o(done_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_stall);
        int  n;
        logic seen;
        @(negedge clk);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b;
        n = 0; seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            if (stall_o) n++;
            @(negedge clk);
        end
        chk({tag, " done"}, {31'd0, seen}, 32'd1);
        chk({tag, " stalls"}, n, exp_stall);
        chk({tag, " result"}, result_o, exp);
        start_i = 1'b0;
    endtask

    initial begin
        logic seen;
        repeat (2) @(negedge clk);
        chk("rst stall", {31'd0, stall_o}, 32'd0);
        chk("rst done", {31'd0, done_o}, 32'd0);
        chk("rst result", result_o, 32'd0);
        reset = 1'b0;

        run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("div neg", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
        run_op("rem neg", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
        run_op("div by0", OP_DIV, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem by0", OP_REM, 32'h1234, 32'd0, 32'h1234, 1);
        run_op("remu by0", OP_REMU, 32'd5, 32'd0, 32'd5, 1);
        run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("mulh", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, MUL_STALLS);
        run_op("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_STALLS);
        run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_STALLS);
        run_op("mul", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, MUL_STALLS);
        run_op("mul shift", OP_MUL, 32'h1234_5678, 32'h10, 32'h2345_6780, MUL_STALLS);
        run_op("mulh neg", OP_MULH, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, MUL_STALLS);
        run_op("mul neg", OP_MUL, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFEB, MUL_STALLS);

        @(negedge clk);
        start_i = 1'b1; op_i = 5'd0; a_i = 32'd1; b_i = 32'd1;
        #1 chk("non-m stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        #1 chk("non-m done", {31'd0, done_o}, 32'd0);
        chk("hold result", result_o, 32'hFFFF_FFEB);
        start_i = 1'b0;

        @(negedge clk);
        start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd1000; b_i = 32'd7;
        #1 chk("flush c0 stall", {31'd0, stall_o}, 32'd1);
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        #1 chk("flush stall", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        flush_i = 1'b0; start_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1 if (done_o) seen = 1'b1;
            @(negedge clk);
        end
        chk("flush no done", {31'd0, seen}, 32'd0);
        chk("flush result", result_o, 32'hFFFF_FFEB);
        run_op("divu post flush", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

        @(negedge clk);
        start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd50; b_i = 32'd5;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1 chk("mid rst stall", {31'd0, stall_o}, 32'd0);
        chk("mid rst result", result_o, 32'd0);
        chk("mid rst done", {31'd0, done_o}, 32'd0);
        @(negedge clk);
        reset = 1'b0; start_i = 1'b0;
        run_op("remu post rst", OP_REMU, 32'd100, 32'd7, 32'd2, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage. It consumes the operation code, the forwarded operands and a valid qualifier from the ID/EX pipeline register outputs. It holds the pipeline through a stall request until the result is ready, then presents a registered 32-bit result for the EX/MEM result mux. It covers MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- start_i  in  1  valid M-extension instruction in EX (not flushed).
- op_i  in  5  ALUControlE. M codes: MUL=01010, MULH=01011, MULHSU=01100, MULHU=01101, DIV=01110, DIVU=01111, REM=10000, REMU=10001.
- a_i  in  32  forwarded rs1 operand.
- b_i  in  32  forwarded rs2 operand.
- flush_i  in  1  FlushE; kills any operation in progress.
- stall_o  out  1  to the hazard unit; drives StallF, StallD and StallE.
- done_o  out  1  result valid this cycle.
- result_o  out  32  result; held until the next accepted operation.

## Operation
- An operation is accepted only when start_i is high, op_i is one of the eight M codes, and the FSM is in IDLE. Other op codes are ignored: stall_o stays 0.
- Operands and op are latched on acceptance. The pipeline stall keeps a_i, b_i and op_i stable but they are not re-read afterwards.
- FSM states:
  - IDLE: accept, then go to CALC. A special case goes straight to DONE.
  - CALC: one iteration per cycle. A 5-bit counter runs 0..31; at 31, go to DONE.
  - DONE: result_o updates, done_o=1. Go to IDLE on the next cycle unconditionally.
- Division is restoring division on operand magnitudes. Quotient sign = sign(a)^sign(b); remainder sign = sign(a). Unsigned ops skip sign handling.
- Multiplication (shift-add build) uses magnitudes, producing a 64-bit product with sign fix-up:
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU: both unsigned.
  - MUL returns product[31:0]; MULH* return product[63:32].
- Special cases are resolved in IDLE and go directly to DONE:
  - b=0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - DIV with a=0x80000000, b=0xFFFFFFFF gives 0x80000000; REM gives 0.
- stall_o = start_i & M-code & (state != DONE) & ~flush_i & ~reset. It is combinational, so the first cycle of an instruction already stalls.
- flush_i is synchronous with priority over everything except reset. The FSM goes to IDLE, the counter clears, and result_o is unchanged. No done_o is produced for a killed operation.

## Timing
- Reset values: state=IDLE, counter=0, result_o=0, done_o=0, stall_o=0.
- Iterative op: accepted in cycle 0, CALC in cycles 1..32, DONE in cycle 33. stall_o is high in cycles 0..32 (33 cycles). The instruction leaves EX at the end of cycle 33.
- Special-case op: stall_o is high in cycle 0 only; DONE is cycle 1.
- Back-to-back M ops: after DONE the FSM returns to IDLE and accepts the next op one cycle later. That IDLE cycle has stall_o=1 if the new op is present.
- Reset asserted mid-CALC aborts immediately; all outputs take their reset values.

## Configuration
- MULDIV_FAST_MUL_EN defined: multiply ops use a single-cycle 64-bit combinational product. They go IDLE→DONE with 1 stall cycle. Division is unchanged.
- Undefined: multiply ops use the 32-iteration shift-add path, with the same 33-cycle latency as division.

## Test plan
- DIVU a=100, b=7 → exactly 33 stall cycles, then done_o with result 14; REMU gives 2.
- DIV a=0xFFFFFF9C (−100), b=7 → 0xFFFFFFF2 (−14); REM → 0xFFFFFFFE (−2).
- DIV by 0 with a=0x1234 → 0xFFFFFFFF; REM by 0 → 0x1234; DIV 0x80000000/−1 → 0x80000000. Each case: 1 stall cycle.
- MULH a=0xFFFFFFFF, b=0xFFFFFFFF → 0; MULHU → 0xFFFFFFFE; MULHSU → 0xFFFFFFFF; MUL → 1. Check stall counts with and without MULDIV_FAST_MUL_EN (1 vs 33).
- flush_i at CALC cycle 10 → stall_o drops the same cycle, no done_o, result_o keeps its previous value. The next DIVU 9/3 returns 3.
- reset pulse at CALC cycle 5 → state IDLE, result_o=0, stall_o=0. An op immediately after reset completes normally.
